// File: rtl/rs_chien.sv
// Chien search for the RS decoder: evaluates the error locator at every codeword
// position, one position per clock, and reports the roots found plus a failure flag.
package gf_pkg;
   localparam int SYMB_WIDTH = 8;
   localparam int SYMB_NUM   = 1 << SYMB_WIDTH;
   localparam int T_LEN      = 4;
   localparam int N_LEN      = 60;
   // Low byte of the primitive polynomial x^8+x^4+x^3+x^2+1
   localparam logic [SYMB_WIDTH-1:0] PRIM_POLY = 8'h1D;

   function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
      logic [SYMB_WIDTH-1:0] acc;
      logic [SYMB_WIDTH-1:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) acc ^= x;
         x = x[SYMB_WIDTH-1] ? ({x[SYMB_WIDTH-2:0], 1'b0} ^ PRIM_POLY) : {x[SYMB_WIDTH-2:0], 1'b0};
      end
      return acc;
   endfunction

   function automatic logic [SYMB_WIDTH-1:0] gf_pow(input int e);
      logic [SYMB_WIDTH-1:0] r;
      r = SYMB_WIDTH'(1);
      for (int i = 0; i < e % (SYMB_NUM - 1); i++) r = gf_mul(r, SYMB_WIDTH'(2));
      return r;
   endfunction
endpackage

module rs_chien
   import gf_pkg::*;
(
   input  logic                                 aclk,
   input  logic                                 areset,
   input  logic [T_LEN:0][SYMB_WIDTH-1:0]       err_loc,
   input  logic                                 err_loc_vld,
   output logic                                 err_loc_rdy,
   output logic [T_LEN-1:0][SYMB_WIDTH-1:0]     error_positions,
   output logic [T_LEN-1:0]                     error_positions_vld,
   output logic                                 decode_fail,
   output logic                                 out_vld,
   input  logic                                 out_rdy
);
   localparam int PW = $clog2(N_LEN);
   localparam int CW = $clog2(T_LEN + 1);
   localparam logic [PW-1:0] P_LAST = PW'(N_LEN - 1);
   localparam logic [CW-1:0] T_MAX  = CW'(T_LEN);

   typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

   state_t                              state_reg, state_next;
   logic [T_LEN:0][SYMB_WIDTH-1:0]      lambda_reg, lambda_next;
   logic [T_LEN:1][SYMB_WIDTH-1:0]      term_reg, term_next;
   logic [T_LEN:1][SYMB_WIDTH-1:0]      load_term, step_term;
   logic [CW-1:0]                       deg_reg, deg_next;
   logic [CW-1:0]                       cnt_reg, cnt_next;
   logic [PW-1:0]                       p_cnt_reg, p_cnt_next;
   logic                                overflow_reg, overflow_next;
   logic [T_LEN-1:0][SYMB_WIDTH-1:0]    pos_reg, pos_next;
   logic [T_LEN-1:0]                    pos_vld_reg, pos_vld_next;
   logic                                fail_reg, fail_next;
   logic [SYMB_WIDTH-1:0]               sum;

   // Term k starts at lambda_k*alpha^(-k(N_LEN-1)) so that step p evaluates at alpha^-(N_LEN-1-p)
   genvar gi;
   generate
      for (gi = 1; gi <= T_LEN; gi++) begin : g_term
         localparam logic [SYMB_WIDTH-1:0] LOAD_C = gf_pow(gi * (SYMB_NUM - N_LEN));
         localparam logic [SYMB_WIDTH-1:0] STEP_C = gf_pow(gi);
         assign load_term[gi] = gf_mul(lambda_reg[gi], LOAD_C);
         assign step_term[gi] = gf_mul(term_reg[gi], STEP_C);
      end
   endgenerate

   always_comb begin
      sum = lambda_reg[0];
      for (int k = 1; k <= T_LEN; k++) sum ^= term_reg[k];
   end

   always_comb begin
      state_next    = state_reg;
      lambda_next   = lambda_reg;
      term_next     = term_reg;
      deg_next      = deg_reg;
      cnt_next      = cnt_reg;
      p_cnt_next    = p_cnt_reg;
      overflow_next = overflow_reg;
      pos_next      = pos_reg;
      pos_vld_next  = pos_vld_reg;
      fail_next     = fail_reg;
      case (state_reg)
         IDLE: begin
            if (err_loc_vld) begin
               lambda_next = err_loc;
               cnt_next    = '0;
               state_next  = LOAD;
            end
         end
         LOAD: begin
            term_next     = load_term;
            deg_next      = '0;
            for (int k = 1; k <= T_LEN; k++)
               if (lambda_reg[k] != '0) deg_next = CW'(k);
            p_cnt_next    = '0;
            overflow_next = 1'b0;
            pos_next      = '0;
            pos_vld_next  = '0;
            fail_next     = 1'b0;
            state_next    = SEARCH;
         end
         SEARCH: begin
            if (sum == '0) begin
               if (cnt_reg < T_MAX) begin
                  for (int s = 0; s < T_LEN; s++) begin
                     if (cnt_reg == CW'(s)) begin
                        pos_next[s]     = SYMB_WIDTH'(p_cnt_reg);
                        pos_vld_next[s] = 1'b1;
                     end
                  end
                  cnt_next = cnt_reg + CW'(1);
               end else begin
                  overflow_next = 1'b1;
               end
            end
            term_next  = step_term;
            p_cnt_next = p_cnt_reg + PW'(1);
            if (p_cnt_reg == P_LAST) begin
               p_cnt_next = '0;
               fail_next  = (cnt_next != deg_reg) | overflow_next | (lambda_reg[0] == '0);
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_rdy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg    <= IDLE;
         lambda_reg   <= '0;
         term_reg     <= '0;
         deg_reg      <= '0;
         cnt_reg      <= '0;
         p_cnt_reg    <= '0;
         overflow_reg <= 1'b0;
         pos_reg      <= '0;
         pos_vld_reg  <= '0;
         fail_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lambda_reg   <= lambda_next;
         term_reg     <= term_next;
         deg_reg      <= deg_next;
         cnt_reg      <= cnt_next;
         p_cnt_reg    <= p_cnt_next;
         overflow_reg <= overflow_next;
         pos_reg      <= pos_next;
         pos_vld_reg  <= pos_vld_next;
         fail_reg     <= fail_next;
      end
   end

   assign err_loc_rdy         = (state_reg == IDLE);
   assign out_vld             = (state_reg == DONE);
   assign error_positions     = pos_reg;
   assign error_positions_vld = pos_vld_reg;
   assign decode_fail         = fail_reg;
endmodule

// File: tb/tb_rs_chien.sv
// Scoreboard bench for rs_chien: an independent GF(256) model predicts roots,
// slot contents and the failure flag for each polynomial sent.
module tb_rs_chien;
   import gf_pkg::*;

   typedef logic [SYMB_WIDTH-1:0]              sym_t;
   typedef logic [T_LEN:0][SYMB_WIDTH-1:0]     poly_t;
   typedef struct {
      logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos;
      logic [T_LEN-1:0]                 vld;
      logic                             fail;
   } exp_t;

   localparam sym_t RED = 8'h1D;

   logic                               aclk = 1'b0;
   logic                               areset = 1'b1;
   poly_t                              err_loc = '0;
   logic                               err_loc_vld = 1'b0;
   logic                               err_loc_rdy;
   logic [T_LEN-1:0][SYMB_WIDTH-1:0]   error_positions;
   logic [T_LEN-1:0]                   error_positions_vld;
   logic                               decode_fail;
   logic                               out_vld;
   logic                               out_rdy = 1'b0;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   rs_chien dut (
      .aclk(aclk), .areset(areset),
      .err_loc(err_loc), .err_loc_vld(err_loc_vld), .err_loc_rdy(err_loc_rdy),
      .error_positions(error_positions), .error_positions_vld(error_positions_vld),
      .decode_fail(decode_fail), .out_vld(out_vld), .out_rdy(out_rdy)
   );

   always #5 aclk = ~aclk;

   function automatic sym_t tb_mul(sym_t a, sym_t b);
      sym_t r = '0;
      sym_t x = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) r ^= x;
         x = x[SYMB_WIDTH-1] ? ((x << 1) ^ RED) : (x << 1);
      end
      return r;
   endfunction

   function automatic sym_t tb_alpha(int e);
      sym_t r = 8'd1;
      for (int i = 0; i < e % (SYMB_NUM - 1); i++) r = tb_mul(r, 8'd2);
      return r;
   endfunction

   // Lambda with roots alpha^-j for each listed degree j
   function automatic poly_t poly_from_roots(int js[T_LEN], int n);
      poly_t p = '0;
      poly_t q;
      sym_t  a;
      p[0] = 8'd1;
      for (int r = 0; r < n; r++) begin
         a = tb_alpha(js[r]);
         q = p;
         for (int k = 1; k <= T_LEN; k++) q[k] = p[k] ^ tb_mul(a, p[k-1]);
         p = q;
      end
      return p;
   endfunction

   function automatic exp_t model(poly_t p);
      exp_t e;
      int   cnt = 0;
      int   deg = 0;
      bit   ovf = 0;
      sym_t x, acc;
      e.pos = '0;
      e.vld = '0;
      for (int k = 1; k <= T_LEN; k++) if (p[k] != 0) deg = k;
      for (int pos = 0; pos < N_LEN; pos++) begin
         x   = tb_alpha((SYMB_NUM - 1) - (N_LEN - 1 - pos));
         acc = p[T_LEN];
         for (int k = T_LEN - 1; k >= 0; k--) acc = tb_mul(acc, x) ^ p[k];
         if (acc == 0) begin
            if (cnt < T_LEN) begin
               e.pos[cnt] = sym_t'(pos);
               e.vld[cnt] = 1'b1;
               cnt++;
            end else ovf = 1;
         end
      end
      e.fail = (cnt != deg) || ovf || (p[0] == 0);
      return e;
   endfunction

   task automatic send(input poly_t p);
      int n = 0;
      @(negedge aclk);
      err_loc     = p;
      err_loc_vld = 1'b1;
      while (!err_loc_rdy && n < 200) begin
         @(negedge aclk);
         n++;
      end
      checks++;
      if (!err_loc_rdy) begin
         errors++;
         $display("FAIL send_rdy: err_loc_rdy=%0b required 1 within 200 cycles", err_loc_rdy);
      end
      @(posedge aclk);
      sb_q.push_back(model(p));
      #1 err_loc_vld = 1'b0;
   endtask

   // Waits for the result, compares against the scoreboard, holds out_rdy low for
   // 'delay' cycles checking stability, then completes the output handshake.
   task automatic receive(input int delay, input string name);
      int   n = 0;
      exp_t e;
      do begin
         @(negedge aclk);
         n++;
      end while (!out_vld && n < N_LEN + 20);
      checks++;
      if (n != N_LEN + 2 || !out_vld) begin
         errors++;
         $display("FAIL %s_latency: out_vld after %0d cycles (out_vld=%0b) required %0d", name, n, out_vld, N_LEN + 2);
      end
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_scoreboard: queue empty required one entry", name);
         return;
      end
      e = sb_q.pop_front();
      for (int d = 0; d <= delay; d++) begin
         if (d > 0) @(negedge aclk);
         checks += 4;
         if (error_positions_vld !== e.vld) begin
            errors++;
            $display("FAIL %s_mask[%0d]: got %b required %b", name, d, error_positions_vld, e.vld);
         end
         if (error_positions !== e.pos) begin
            errors++;
            $display("FAIL %s_positions[%0d]: got %h required %h", name, d, error_positions, e.pos);
         end
         if (decode_fail !== e.fail) begin
            errors++;
            $display("FAIL %s_decode_fail[%0d]: got %0b required %0b", name, d, decode_fail, e.fail);
         end
         if (out_vld !== 1'b1 || err_loc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold[%0d]: out_vld=%0b err_loc_rdy=%0b required 1/0", name, d, out_vld, err_loc_rdy);
         end
      end
      $display("%s: mask=%b positions=%h fail=%0b latency=%0d", name, error_positions_vld, error_positions, decode_fail, n);
      out_rdy = 1'b1;
      @(posedge aclk);
      #1 out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(negedge aclk);
      checks++;
      if (err_loc_rdy !== 1'b1 || out_vld !== 1'b0 || decode_fail !== 1'b0 ||
          error_positions_vld !== '0 || error_positions !== '0) begin
         errors++;
         $display("FAIL reset_values: rdy=%0b vld=%0b fail=%0b mask=%b pos=%h required 1/0/0/0/0",
                  err_loc_rdy, out_vld, decode_fail, error_positions_vld, error_positions);
      end
      $display("reset: rdy=%0b out_vld=%0b", err_loc_rdy, out_vld);
   endtask

   task automatic test_no_errors();
      poly_t p = '0;
      p[0] = 8'd1;
      send(p);
      receive(0, "no_errors");
   endtask

   task automatic test_single();
      int js[T_LEN] = '{default: 0};
      js[0] = N_LEN - 11;
      send(poly_from_roots(js, 1));
      receive(0, "single_p10");
   endtask

   task automatic test_full();
      int js[T_LEN];
      js[0] = N_LEN - 1 - 0;
      js[1] = N_LEN - 1 - 7;
      js[2] = N_LEN - 1 - 30;
      js[3] = N_LEN - 1 - (N_LEN - 1);
      send(poly_from_roots(js, T_LEN));
      receive(0, "full_t_errors");
   endtask

   task automatic test_uncorrectable();
      int js[T_LEN] = '{default: 0};
      js[0] = N_LEN;
      js[1] = N_LEN + 1;
      send(poly_from_roots(js, 2));
      receive(0, "uncorrectable");
   endtask

   task automatic test_zero_poly();
      send('0);
      receive(0, "zero_poly");
   endtask

   task automatic test_random();
      int js[T_LEN];
      int n;
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(1, T_LEN);
         for (int r = 0; r < T_LEN; r++) js[r] = N_LEN - 1 - $urandom_range(0, N_LEN - 1);
         send(poly_from_roots(js, n));
         receive(0, "random_roots");
      end
   endtask

   task automatic test_backpressure();
      int    js[T_LEN] = '{default: 0};
      poly_t b;
      js[0] = N_LEN - 1 - 3;
      js[1] = N_LEN - 1 - 44;
      b = poly_from_roots(js, 2);
      js[0] = N_LEN - 1 - 12;
      send(poly_from_roots(js, 1));
      err_loc     = b;
      err_loc_vld = 1'b1;
      receive(5, "backpressure");
      @(negedge aclk);
      checks++;
      if (err_loc_rdy !== 1'b1 || out_vld !== 1'b0) begin
         errors++;
         $display("FAIL bp_reaccept: err_loc_rdy=%0b out_vld=%0b required 1/0", err_loc_rdy, out_vld);
      end
      @(posedge aclk);
      sb_q.push_back(model(b));
      #1 err_loc_vld = 1'b0;
      @(negedge aclk);
      checks++;
      if (err_loc_rdy !== 1'b0) begin
         errors++;
         $display("FAIL bp_load_rdy: err_loc_rdy=%0b required 0", err_loc_rdy);
      end
      // receive counts from the handshake edge; one cycle has already elapsed
      begin
         int n = 1;
         exp_t e;
         while (!out_vld && n < N_LEN + 20) begin
            @(negedge aclk);
            n++;
         end
         checks++;
         if (n != N_LEN + 2) begin
            errors++;
            $display("FAIL bp_second_latency: got %0d required %0d", n, N_LEN + 2);
         end
         e = sb_q.pop_front();
         checks++;
         if (error_positions_vld !== e.vld || error_positions !== e.pos || decode_fail !== e.fail) begin
            errors++;
            $display("FAIL bp_second_result: mask=%b pos=%h fail=%0b required %b %h %0b",
                     error_positions_vld, error_positions, decode_fail, e.vld, e.pos, e.fail);
         end
         $display("backpressure_next: mask=%b positions=%h fail=%0b", error_positions_vld, error_positions, decode_fail);
         out_rdy = 1'b1;
         @(posedge aclk);
         #1 out_rdy = 1'b0;
      end
   endtask

   task automatic test_mid_reset();
      int js[T_LEN] = '{default: 0};
      bit seen = 0;
      js[0] = N_LEN - 1 - 5;
      send(poly_from_roots(js, 1));
      repeat (22) @(negedge aclk);
      areset = 1'b1;
      @(posedge aclk);
      #1 areset = 1'b0;
      void'(sb_q.pop_back());
      checks++;
      if (err_loc_rdy !== 1'b1 || out_vld !== 1'b0 || decode_fail !== 1'b0 ||
          error_positions_vld !== '0 || error_positions !== '0) begin
         errors++;
         $display("FAIL mid_reset_values: rdy=%0b vld=%0b fail=%0b mask=%b pos=%h required 1/0/0/0/0",
                  err_loc_rdy, out_vld, decode_fail, error_positions_vld, error_positions);
      end
      for (int c = 0; c < N_LEN + 5; c++) begin
         @(negedge aclk);
         if (out_vld) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_reset_no_out: out_vld seen=%0b required 0", seen);
      end
      $display("mid_reset: discarded in-flight polynomial");
      js[0] = N_LEN - 1 - 21;
      js[1] = N_LEN - 1 - 50;
      js[2] = N_LEN - 1 - 2;
      send(poly_from_roots(js, 3));
      receive(0, "after_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_no_errors();
      test_single();
      test_full();
      test_uncorrectable();
      test_zero_poly();
      test_random();
      test_backpressure();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
